// File: rtl/mw_add_seq.sv
// Sequential multi-word adder around an external 16-bit adder, LS word first.
// Define MWADD_OVF_EN to add the registered signed-overflow output out_ovf.
module mw_add_seq #(
  parameter int MAXW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_first,
  input  logic        in_last,
  input  logic        in_cin,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [16:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        out_last,
  output logic        out_cout,
`ifdef MWADD_OVF_EN
  output logic        out_ovf,
`endif
  output logic        err
);

  localparam int CW = $clog2(MAXW + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MID  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          carry_q;

  logic          op_valid_q, op_first_q, op_last_q, op_cin_q;
  logic [15:0]   op_a_q, op_b_q;

  logic          out_valid_q, out_last_q, out_cout_q;
  logic [15:0]   out_sum_q;

  logic          xfer, accept, idle, eff_first;
  logic          force_last, beat_last;
  logic [CW-1:0] wcnt;
  logic          unused_sum16;

  assign unused_sum16 = add_sum[16];

  always_comb begin
    xfer       = op_valid_q & (~out_valid_q | out_ready);
    in_ready   = ~op_valid_q | xfer;
    accept     = in_valid & in_ready;
    idle       = (state_q == IDLE);
    // A non-first word in IDLE is forced to start a new operand
    eff_first  = in_first | idle;
    wcnt       = eff_first ? CW'(1) : cnt_q + CW'(1);
    force_last = ~in_last & (wcnt == CW'(MAXW));
    beat_last  = in_last | force_last;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (accept) begin
      state_d = beat_last ? IDLE : MID;
      cnt_d   = beat_last ? '0 : wcnt;
      if ((in_first != idle) | force_last)
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_first_q <= 1'b0;
      op_last_q  <= 1'b0;
      op_cin_q   <= 1'b0;
    end else if (accept) begin
      op_valid_q <= 1'b1;
      op_a_q     <= in_a;
      op_b_q     <= in_b;
      op_first_q <= eff_first;
      op_last_q  <= beat_last;
      op_cin_q   <= in_first & in_cin;
    end else if (xfer) begin
      op_valid_q <= 1'b0;
    end
  end

  assign add_a   = op_a_q;
  assign add_b   = op_b_q;
  assign add_cin = op_first_q ? op_cin_q : carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      carry_q     <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= add_sum[15:0];
      out_last_q  <= op_last_q;
      out_cout_q  <= add_cout;
      carry_q     <= add_cout;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MWADD_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (xfer)
      ovf_q <= op_last_q & (op_a_q[15] == op_b_q[15])
             & (add_sum[15] != op_a_q[15]);
  end

  assign out_ovf = ovf_q;
`endif

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign err       = err_q;

endmodule

// File: doc/mw_add_seq.md
MW_ADD_SEQ -- requirements
Module: mw_add_seq

Interface
REQ-001 SHALL have parameter MAXW, default 4, meaning the maximum number of 16-bit words per operand (2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1): upstream beat handshake.
REQ-005 SHALL have ports in_a (input, 16), in_b (input, 16): operand words, least-significant word first.
REQ-006 SHALL have ports in_first (input, 1), in_last (input, 1), in_cin (input, 1): operand delimiters; carry-in used on the first word only.
REQ-007 SHALL have ports add_a (output, 16), add_b (output, 16), add_cin (output, 1), driving the external bit16adder.
REQ-008 SHALL have ports add_sum (input, 17), add_cout (input, 1), returned from bit16adder; add_sum[16] is ignored.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1): downstream handshake.
REQ-010 SHALL have ports out_sum (output, 16), out_last (output, 1), out_cout (output, 1): result word, end marker, carry-out of that word.
REQ-011 SHALL have port err (output, 1): sticky protocol-error flag.

Function
REQ-012 SHALL accept a beat only when in_valid and in_ready are both high in the same cycle.
REQ-013 SHALL hold the accepted beat in an operand stage (op_valid, op_a, op_b, op_first, op_last, op_cin).
REQ-014 SHALL drive add_a = op_a and add_b = op_b; add_cin = op_cin when op_first, else the carry register.
REQ-015 SHALL move the operand stage into the output stage when op_valid and (!out_valid or out_ready), capturing add_sum[15:0], add_cout and op_last.
REQ-016 SHALL update the carry register with add_cout on every operand-to-output transfer.
REQ-017 SHALL drive in_ready = !op_valid or (operand-to-output transfer occurring this cycle).
REQ-018 SHALL produce out_valid exactly 2 cycles after acceptance when out_ready stays high; full throughput of 1 word/cycle.
REQ-019 SHALL hold out_sum/out_last/out_cout stable while out_valid and !out_ready.
REQ-020 SHALL implement the states IDLE (expecting first word) and MID (inside operand), with a word counter.
REQ-021 SHALL transition IDLE->MID on an accepted beat with in_first and !in_last; single-word operand (first and last) remains IDLE.
REQ-022 SHALL transition MID->IDLE on an accepted beat with in_last.
REQ-023 SHALL, on an accepted beat without in_first in IDLE, treat it as a first word with cin=0 and set err.
REQ-024 SHALL, on an accepted beat with in_first in MID, restart the operand (new first word) and set err.
REQ-025 SHALL, when the word counter reaches MAXW without in_last, force out_last on that word, set err and return to IDLE.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear: op_valid=0, out_valid=0, out_sum=0, out_last=0, out_cout=0, carry=0, err=0, state=IDLE, counter=0.
REQ-027 SHALL drive in_ready=1 after reset; a reset mid-operand discards all partial words.

Configuration
REQ-028 SHALL, with macro MWADD_OVF_EN defined, add output out_ovf (1 bit), registered with the word: on out_last words, signed overflow (operand sign bits equal, result sign differs), else 0; reset 0.
REQ-029 SHALL, without MWADD_OVF_EN, omit out_ovf and all its logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover: reset, then single word 0xF017+0xC653, cin=0 -> out_sum 0xB66A, out_cout 1, out_last 1, 2 cycles later.
REQ-031 SHALL cover: single word 0xEFAC+0x9087, cin=1 -> out_sum 0x8034, out_cout 1.
REQ-032 SHALL cover: two-word operand, low 0xF017/0xC653 cin 0, high 0x3F40/0x567D -> words 0xB66A then 0x95BE, final out_cout 0, out_ovf 1 (when enabled).
REQ-033 SHALL cover: out_ready held low 3 cycles with stream active -> in_ready drops after 1 beat is buffered, no loss, outputs stable.
REQ-034 SHALL cover: beat without in_first in IDLE, and MAXW+1 words without in_last -> err=1, forced out_last on word MAXW.
REQ-035 SHALL cover: rst_n pulsed low mid-operand -> out_valid=0 immediately, next beat processed with carry 0.
